// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch-front program counter: next-PC mode encodings
// and the default address/offset widths also used by the decode stage.
package pc_seq_pkg;

    localparam logic [1:0] MODE_INC    = 2'b00;
    localparam logic [1:0] MODE_BRANCH = 2'b01;
    localparam logic [1:0] MODE_JUMP   = 2'b10;
    localparam logic [1:0] MODE_RET    = 2'b11;

    localparam int PC_ADDR_W = 15;
    localparam int PC_OFF_W  = 8;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push when full overwrites the oldest entry,
// so the newest RAS_DEPTH links always stay valid; count saturates at RAS_DEPTH.
module ras_stack #(
    parameter  int ADDR_W    = 15,
    parameter  int RAS_DEPTH = 8,
    localparam int PTR_W     = $clog2(RAS_DEPTH),
    localparam int CNT_W     = $clog2(RAS_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top_data,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow_pulse,
    output logic              underflow_pulse
);

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_top;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // ptr_q points at the next free slot; the top entry sits just below it.
    assign ptr_top         = ptr_q - 1'b1;
    assign top_data        = mem_q[ptr_top];
    assign count           = cnt_q;
    assign empty           = (cnt_q == '0);
    assign full            = (cnt_q == CNT_W'(RAS_DEPTH));
    assign overflow_pulse  = push && full;
    assign underflow_pulse = pop && empty;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push) begin
            ptr_d = ptr_q + 1'b1;
            if (!full) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (pop && !empty) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with internal next-PC selection: increment, relative branch,
// absolute jump (optionally with link push) and return through a RAS.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter  int                ADDR_W    = PC_ADDR_W,
    parameter  int                OFF_W     = PC_OFF_W,
    parameter  int                RAS_DEPTH = 8,
    parameter  logic [ADDR_W-1:0] RESET_VEC = '0,
    localparam int                CNT_W     = $clog2(RAS_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_en,
    input  logic [1:0]        mode,
    input  logic              br_taken,
    input  logic [OFF_W-1:0]  br_off,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              call,
    output logic [ADDR_W-1:0] PC,
    output logic [CNT_W-1:0]  ras_count,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_err
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] link, off_ext, top_data;
    logic              push, pop, overflow_pulse, underflow_pulse;

    assign link    = pc_q + 1'b1;
    assign off_ext = ADDR_W'($signed(br_off));

    // A stalled cycle must leave the stack untouched, so both requests are gated.
    assign push = pc_en && (mode == MODE_JUMP) && call;
    assign pop  = pc_en && (mode == MODE_RET);

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk             (clk),
        .reset           (reset),
        .push            (push),
        .pop             (pop),
        .push_data       (link),
        .top_data        (top_data),
        .count           (ras_count),
        .empty           (ras_empty),
        .full            (ras_full),
        .overflow_pulse  (overflow_pulse),
        .underflow_pulse (underflow_pulse)
    );

    always_comb begin
        pc_d = link;
        unique case (mode)
            MODE_INC:    pc_d = link;
            MODE_BRANCH: pc_d = br_taken ? (link + off_ext) : link;
            MODE_JUMP:   pc_d = jump_addr;
            MODE_RET:    pc_d = ras_empty ? link : top_data;
            default:     pc_d = link;
        endcase
    end

    assign err_d = err_q || overflow_pulse || underflow_pulse;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_VEC;
            err_q <= 1'b0;
        end else if (pc_en) begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    assign PC      = pc_q;
    assign ras_err = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized and directed bench for pc_sequencer against a queue-based model
// of the PC and the return-address stack.
module tb_pc_sequencer;
    localparam int ADDR_W    = 15;
    localparam int OFF_W     = 8;
    localparam int RAS_DEPTH = 8;
    localparam int CNT_W     = $clog2(RAS_DEPTH + 1);
    localparam int MASK      = (1 << ADDR_W) - 1;

    logic              clk = 1'b0;
    logic              reset, pc_en, br_taken, call;
    logic [1:0]        mode;
    logic [OFF_W-1:0]  br_off;
    logic [ADDR_W-1:0] jump_addr;
    logic [ADDR_W-1:0] PC;
    logic [CNT_W-1:0]  ras_count;
    logic              ras_empty, ras_full, ras_err;

    int checks = 0;
    int errors = 0;

    // reference model state
    int pc_m;
    int ras_m[$];
    bit err_m;

    pc_sequencer #(
        .ADDR_W    (ADDR_W),
        .OFF_W     (OFF_W),
        .RAS_DEPTH (RAS_DEPTH),
        .RESET_VEC ('0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pc_en     (pc_en),
        .mode      (mode),
        .br_taken  (br_taken),
        .br_off    (br_off),
        .jump_addr (jump_addr),
        .call      (call),
        .PC        (PC),
        .ras_count (ras_count),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_err   (ras_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_step(input bit rst, input bit en, input logic [1:0] m, input bit bt,
                              input logic [OFF_W-1:0] off, input int ja, input bit cl);
        int link;
        int s;
        if (rst) begin
            pc_m  = 0;
            err_m = 0;
            ras_m.delete();
        end else if (en) begin
            link = (pc_m + 1) & MASK;
            case (m)
                2'b00: pc_m = link;
                2'b01: begin
                    s    = $signed(off);
                    pc_m = bt ? ((link + s) & MASK) : link;
                end
                2'b10: begin
                    pc_m = ja & MASK;
                    if (cl) begin
                        ras_m.push_back(link);
                        if (ras_m.size() > RAS_DEPTH) begin
                            void'(ras_m.pop_front());
                            err_m = 1;
                        end
                    end
                end
                default: begin
                    if (ras_m.size() > 0) pc_m = ras_m.pop_back();
                    else begin
                        pc_m  = link;
                        err_m = 1;
                    end
                end
            endcase
        end
    endtask

    // Drive one cycle, advance the model, then compare every output #1 after the edge.
    task automatic cycle(input bit rst, input bit en, input logic [1:0] m, input bit bt,
                         input logic [OFF_W-1:0] off, input int ja, input bit cl);
        reset     = rst;
        pc_en     = en;
        mode      = m;
        br_taken  = bt;
        br_off    = off;
        jump_addr = ADDR_W'(ja);
        call      = cl;
        model_step(rst, en, m, bt, off, ja, cl);
        @(posedge clk);
        #1;
        check("pc",    32'(PC),        32'(pc_m));
        check("count", 32'(ras_count), 32'(ras_m.size()));
        check("empty", 32'(ras_empty), 32'(ras_m.size() == 0));
        check("full",  32'(ras_full),  32'(ras_m.size() == RAS_DEPTH));
        check("err",   32'(ras_err),   32'(err_m));
    endtask

    task automatic do_reset();
        cycle(1, 0, 2'b00, 0, '0, 0, 0);
    endtask

    task automatic inc();
        cycle(0, 1, 2'b00, 0, '0, 0, 0);
    endtask

    task automatic jmp(input int a, input bit cl);
        cycle(0, 1, 2'b10, 0, '0, a, cl);
    endtask

    task automatic ret();
        cycle(0, 1, 2'b11, 0, '0, 0, 0);
    endtask

    initial begin
        reset = 1; pc_en = 0; mode = 0; br_taken = 0; br_off = 0; jump_addr = 0; call = 0;
        @(negedge clk);

        // reset and simple increment, then a stall that must ignore a call
        do_reset();
        check("rst_pc", 32'(PC), 32'h0);
        check("rst_empty", 32'(ras_empty), 32'h1);
        for (int i = 1; i <= 3; i++) begin
            inc();
            check("inc_seq", 32'(PC), 32'(i));
        end
        cycle(0, 0, 2'b10, 0, '0, 'h123, 1);
        cycle(0, 0, 2'b10, 0, '0, 'h123, 1);
        check("stall_pc", 32'(PC), 32'h3);
        check("stall_cnt", 32'(ras_count), 32'h0);

        // branches and wrap
        jmp('h10, 0);
        cycle(0, 1, 2'b01, 1, 8'hFC, 0, 0);
        check("br_taken", 32'(PC), 32'h0D);
        jmp('h10, 0);
        cycle(0, 1, 2'b01, 0, 8'hFC, 0, 0);
        check("br_not", 32'(PC), 32'h11);
        jmp('h7FFF, 0);
        inc();
        check("inc_wrap", 32'(PC), 32'h0);
        jmp('h7FFE, 0);
        cycle(0, 1, 2'b01, 1, 8'h05, 0, 0);
        check("br_wrap_up", 32'(PC), 32'h4);
        cycle(0, 1, 2'b01, 1, 8'h80, 0, 0);
        check("br_wrap_dn", 32'(PC), 32'h7F85);

        // nested calls and returns
        jmp(5, 0);
        jmp('h100, 1);
        jmp('h200, 1);
        check("nest_cnt", 32'(ras_count), 32'h2);
        ret();
        check("ret1", 32'(PC), 32'h101);
        ret();
        check("ret2", 32'(PC), 32'h6);
        check("ret2_empty", 32'(ras_empty), 32'h1);
        check("ret2_err", 32'(ras_err), 32'h0);

        // return on empty stack is sticky
        jmp('h40, 0);
        ret();
        check("uf_pc", 32'(PC), 32'h41);
        check("uf_err", 32'(ras_err), 32'h1);
        for (int i = 0; i < 5; i++) inc();
        check("uf_sticky", 32'(ras_err), 32'h1);

        // overflow: nine calls, eight returns
        do_reset();
        for (int k = 0; k < 9; k++) jmp(k + 1, 1);
        check("of_full", 32'(ras_full), 32'h1);
        check("of_cnt", 32'(ras_count), 32'h8);
        check("of_err", 32'(ras_err), 32'h1);
        for (int k = 0; k < 8; k++) begin
            ret();
            check("of_ret", 32'(PC), 32'(9 - k));
        end
        check("of_empty", 32'(ras_empty), 32'h1);

        // reset beats a pending return
        do_reset();
        jmp('h30, 1);
        jmp('h31, 1);
        jmp('h32, 1);
        check("pre_rst_cnt", 32'(ras_count), 32'h3);
        cycle(1, 1, 2'b11, 0, '0, 0, 0);
        check("mid_rst_pc", 32'(PC), 32'h0);
        check("mid_rst_cnt", 32'(ras_count), 32'h0);
        check("mid_rst_err", 32'(ras_err), 32'h0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [1:0] m;
            int         ja;
            m  = 2'($urandom_range(0, 3));
            ja = $urandom_range(0, MASK);
            if ($urandom_range(0, 7) == 0) ja = $urandom_range(MASK - 3, MASK);
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 5) != 0, m,
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), ja,
                  $urandom_range(0, 2) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised successor to the single-register program counter. Holds the fetch address and computes the next PC internally: sequential increment, PC-relative conditional branch, absolute jump, call (jump plus link), and return.
- Calls push their return address onto an internal return-address stack (RAS) of configurable depth.
- Sits at the front of the fetch stage. The PC output feeds instruction-memory addressing directly.

Parameters:
- ADDR_W, 15: PC and address width in bits.
- OFF_W, 8: width of the signed branch offset.
- RAS_DEPTH, 8: number of RAS entries. Must be ≥ 2 and a power of two.
- RESET_VEC, 0: PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_en  in  1  advance enable. When 0, all state holds (stall).
- mode  in  2  next-PC select: 00 INC, 01 BRANCH, 10 JUMP, 11 RET.
- br_taken  in  1  branch condition; used only in BRANCH mode.
- br_off  in  OFF_W  signed word offset, two's complement.
- jump_addr  in  ADDR_W  absolute target; used only in JUMP mode.
- call  in  1  with JUMP, push the link address; ignored in every other mode.
- PC  out  ADDR_W  current fetch address (registered).
- ras_count  out  $clog2(RAS_DEPTH+1)  number of valid RAS entries.
- ras_empty  out  1  ras_count == 0.
- ras_full  out  1  ras_count == RAS_DEPTH.
- ras_err  out  1  sticky error: return on an empty RAS, or call on a full RAS.

Behaviour:
- Reset (synchronous, takes priority over everything): PC = RESET_VEC, ras_count = 0, ras_empty = 1, ras_full = 0, ras_err = 0. Stack contents are don't-care. Reset in mid-sequence discards all links.
- pc_en = 0: PC, RAS contents, count and ras_err all hold. mode, call and the other inputs are ignored.
- pc_en = 1, one-cycle latency: the new PC is visible the cycle after the enabling edge. Let link = PC + 1, truncated to ADDR_W.
  - INC: PC <= PC + 1, modulo 2^ADDR_W. 2^ADDR_W − 1 wraps to 0.
  - BRANCH: if br_taken, PC <= PC + 1 + sign_extend(br_off), modulo 2^ADDR_W; otherwise PC <= PC + 1. Wrap applies in both directions, with no error.
  - JUMP: PC <= jump_addr. If call = 1, push link.
  - RET, RAS not empty: PC <= top entry; pop.
  - RET, RAS empty: PC <= PC + 1, ras_err <= 1, count stays 0.
- Push rule: write at top pointer, pointer + 1 modulo RAS_DEPTH, count + 1.
- Push when full: the entry is still written (circular overwrite of the oldest entry). Count saturates at RAS_DEPTH and ras_err <= 1. Newest RAS_DEPTH links remain correct.
- Pop rule: pointer − 1 modulo RAS_DEPTH, count − 1. The top entry is read combinationally before the pointer moves.
- Push and pop never happen in the same cycle, because mode is exclusive.
- ras_err is cleared only by reset.
- ras_empty, ras_full and ras_count are registered-state derived and valid in the cycle after the update.
- Arithmetic is unsigned ADDR_W-bit addition with the carry discarded; br_off is sign-extended to ADDR_W before the add. OFF_W ≤ ADDR_W is required.

Decomposition:
- Shared package pc_seq_pkg:
  - mode encodings MODE_INC = 2'b00, MODE_BRANCH = 2'b01, MODE_JUMP = 2'b10, MODE_RET = 2'b11;
  - default ADDR_W / OFF_W constants shared with the decode stage.
- Sub-module ras_stack (params ADDR_W, RAS_DEPTH):
  - ports clk, reset, push, pop, push_data, top_data, count, empty, full, overflow_pulse, underflow_pulse;
  - owns the circular storage, pointer and count.
- pc_sequencer contains:
  - next-PC mux;
  - offset sign-extension and adder;
  - sticky ras_err register;
  - pc_en gating of push/pop.

Test Plan:
- Reset, then 3 cycles of INC with pc_en = 1 -> PC sequence 0, 1, 2, 3. Hold pc_en = 0 for 2 cycles with mode = JUMP, call = 1 -> PC stays 3 and ras_count stays 0.
- PC = 0x0010, BRANCH with br_taken = 1, br_off = 8'hFC (−4) -> PC = 0x000D. br_taken = 0 -> PC = 0x0011. PC = 0x7FFF with INC -> PC = 0x0000.
- Nested calls: from PC 5, JUMP call = 1 to 0x100; from 0x100, call to 0x200 -> ras_count = 2. RET -> PC = 0x101. RET -> PC = 6, ras_empty = 1, ras_err = 0.
- RET on empty RAS at PC = 0x40 -> PC = 0x41, ras_err = 1, and ras_err stays 1 after 5 further INC cycles.
- RAS_DEPTH = 8: 9 calls from PCs 0..8 (each a JUMP call = 1 to address k+1) -> ras_full = 1, ras_count = 8, ras_err = 1. Eight RETs return 9, 8, …, 2, then ras_empty = 1.
- Reset asserted with ras_count = 3 and pc_en = 1, mode = RET -> next cycle PC = RESET_VEC, ras_count = 0, ras_err = 0, no pop side effect.
